// File: rtl/if_fetch_buffer.sv
// Instruction-fetch prefetch buffer: issues in-order requests to instruction
// memory and queues returned words with their PCs for the decode stage.
module if_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        out_valid_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic [7:0]  out_except_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc4_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          halted;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, discard;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [7:0]  exc_mem   [DEPTH];

  logic          redirect_any;
  logic [31:0]   target_pc;
  logic          aligned;
  logic [CW:0]   occ_sum, out_sum;
  logic          gnt_fire, rvalid_ok, resp_keep, resp_drop;
  logic          mis_push, push, pop;
  logic [31:0]   resp_pc;
  logic [31:0]   push_pc, push_instr;
  logic [7:0]    push_exc;
  logic [CW-1:0] disc_redirect;

  // Requests are gated both by buffer space and by outstanding responses,
  // so neither the FIFO nor the in-flight/discard bookkeeping can overflow.
  always_comb begin
    redirect_any  = flush_i | redirect_i;
    target_pc     = flush_i ? new_pc_i : redirect_pc_i;
    aligned       = (fetch_pc[1:0] == 2'b00);
    occ_sum       = {1'b0, count} + {1'b0, inflight};
    out_sum       = {1'b0, inflight} + {1'b0, discard};
    imem_req_o    = !rst_i && aligned && !halted &&
                    (occ_sum < DEPTH_X) && (out_sum < DEPTH_X);
    imem_addr_o   = fetch_pc;
    gnt_fire      = imem_req_o && imem_gnt_i;
    rvalid_ok     = imem_rvalid_i && ((inflight != '0) || (discard != '0));
    resp_keep     = rvalid_ok && (discard == '0) && !redirect_any;
    resp_drop     = rvalid_ok && (discard != '0);
    mis_push      = !rst_i && !halted && !aligned && (inflight == '0) &&
                    ({1'b0, count} < DEPTH_X) && !redirect_any;
    push          = resp_keep || mis_push;
    pop           = (count != '0) && out_ready_i && !redirect_any;
    // Oldest outstanding request sits inflight words behind the fetch PC.
    resp_pc       = fetch_pc - 32'({inflight, 2'b00});
    push_pc       = mis_push ? fetch_pc : resp_pc;
    push_instr    = mis_push ? 32'h0 : imem_rdata_i;
    push_exc      = mis_push ? 8'h80 : 8'h00;
    disc_redirect = discard + inflight + CW'(gnt_fire) - CW'(rvalid_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_any) begin
      fetch_pc <= target_pc;
      halted   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= disc_redirect;
    end else begin
      if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
      if (mis_push) halted <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(gnt_fire) - CW'(resp_keep);
      discard  <= discard - CW'(resp_drop);
    end
  end

  // Storage needs no reset; the head is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
      exc_mem[wr_ptr]   <= push_exc;
    end
  end

  always_comb begin
    out_valid_o  = (count != '0);
    out_pc_o     = out_valid_o ? pc_mem[rd_ptr]    : 32'h0;
    out_instr_o  = out_valid_o ? instr_mem[rd_ptr] : 32'h0;
    out_except_o = out_valid_o ? exc_mem[rd_ptr]   : 8'h00;
    out_pc4_o    = out_pc_o + 32'd4;
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with an in-order instruction memory
// responder whose data word is derived from the request address.
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, redirect, gnt, rvalid, ready;
  logic [31:0] new_pc, redirect_pc, rdata;
  logic        imem_req_o, out_valid_o;
  logic [31:0] imem_addr_o, out_pc_o, out_instr_o, out_pc4_o;
  logic [7:0]  out_except_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pend_q[$];
  int          grant_cnt;
  logic [31:0] last_grant_addr;
  logic        resp_en;

  always #5 clk = ~clk;

  if_fetch_buffer #(.RESET_PC(32'hBFC00000), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .new_pc_i(new_pc),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
    .out_except_o(out_except_o), .out_ready_i(ready), .out_pc4_o(out_pc4_o)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A0F0F;
  endfunction

  // One clock: sample handshakes mid-cycle, then update the memory model.
  task automatic tick();
    logic        fire, rv;
    logic [31:0] fa;
    @(negedge clk);
    fire = imem_req_o && gnt && !rst;
    fa   = imem_addr_o;
    rv   = rvalid;
    @(posedge clk);
    #1;
    if (rst) begin
      pend_q.delete();
      rvalid = 1'b0;
      rdata  = 32'h0;
    end else begin
      if (rv && pend_q.size() > 0) void'(pend_q.pop_front());
      if (fire) begin
        pend_q.push_back(fa);
        grant_cnt++;
        last_grant_addr = fa;
      end
      if (resp_en && pend_q.size() > 0) begin
        rvalid = 1'b1;
        rdata  = instr_of(pend_q[0]);
      end else begin
        rvalid = 1'b0;
        rdata  = 32'h0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; redirect = 1'b0; gnt = 1'b0; ready = 1'b0;
    resp_en = 1'b0; rvalid = 1'b0; rdata = 32'h0; pend_q.delete();
    tick(); tick();
    rst = 1'b0;
    grant_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt = 1'b1; ready = 1'b1;
    tick(); tick();
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid_o); end
    n_checks++; if (out_pc_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 00000000", out_pc_o); end
    n_checks++; if (out_instr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 00000000", out_instr_o); end
    n_checks++; if (out_except_o !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_except: got %h expected 00", out_except_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_a, exp_p;
    do_reset();
    gnt = 1'b1; ready = 1'b1; resp_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_a = 32'hBFC00000 + 32'(4 * k);
      n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_req[%0d]: got %b expected 1", k, imem_req_o); end
      n_checks++; if (imem_addr_o !== exp_a) begin n_fail++; $display("[TB] FAIL stream_addr[%0d]: got %h expected %h", k, imem_addr_o, exp_a); end
      if (k >= 2) begin
        exp_p = 32'hBFC00000 + 32'(4 * (k - 2));
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", k, out_valid_o); end
        n_checks++; if (out_pc_o !== exp_p) begin n_fail++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", k, out_pc_o, exp_p); end
        n_checks++; if (out_pc4_o !== exp_p + 32'd4) begin n_fail++; $display("[TB] FAIL stream_pc4[%0d]: got %h expected %h", k, out_pc4_o, exp_p + 32'd4); end
        n_checks++; if (out_instr_o !== instr_of(exp_p)) begin n_fail++; $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", k, out_instr_o, instr_of(exp_p)); end
        n_checks++; if (out_except_o !== 8'h00) begin n_fail++; $display("[TB] FAIL stream_except[%0d]: got %h expected 00", k, out_except_o); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    repeat (10) tick();
    n_checks++; if (grant_cnt !== 4) begin n_fail++; $display("[TB] FAIL bp_grants: got %0d expected 4", grant_cnt); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_full: got %b expected 0", imem_req_o); end
    n_checks++; if (out_pc_o !== 32'hBFC00000) begin n_fail++; $display("[TB] FAIL bp_head: got %h expected bfc00000", out_pc_o); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    grant_cnt = 0;
    repeat (6) tick();
    n_checks++; if (grant_cnt !== 1) begin n_fail++; $display("[TB] FAIL bp_one_more: got %0d expected 1", grant_cnt); end
    n_checks++; if (last_grant_addr !== 32'hBFC00010) begin n_fail++; $display("[TB] FAIL bp_next_addr: got %h expected bfc00010", last_grant_addr); end
    n_checks++; if (out_pc_o !== 32'hBFC00004) begin n_fail++; $display("[TB] FAIL bp_head_after_pop: got %h expected bfc00004", out_pc_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b0;
    tick(); tick();
    n_checks++; if (grant_cnt !== 2) begin n_fail++; $display("[TB] FAIL redir_inflight: got %0d expected 2", grant_cnt); end
    gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h00400100;
    tick();
    redirect = 1'b0; gnt = 1'b1; resp_en = 1'b1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_empty: got %b expected 0", out_valid_o); end
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_req: got %b expected 1", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'h00400100) begin n_fail++; $display("[TB] FAIL redir_addr: got %h expected 00400100", imem_addr_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_dropped[%0d]: got %b expected 0", i, out_valid_o); end
    end
    tick();
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_first_valid: got %b expected 1", out_valid_o); end
    n_checks++; if (out_pc_o !== 32'h00400100) begin n_fail++; $display("[TB] FAIL redir_first_pc: got %h expected 00400100", out_pc_o); end
    n_checks++; if (out_instr_o !== instr_of(32'h00400100)) begin n_fail++; $display("[TB] FAIL redir_first_instr: got %h expected %h", out_instr_o, instr_of(32'h00400100)); end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    n_checks++; if (imem_addr_o !== 32'hFFFFFFFC) begin n_fail++; $display("[TB] FAIL wrap_addr0: got %h expected fffffffc", imem_addr_o); end
    tick();
    n_checks++; if (imem_addr_o !== 32'h00000000) begin n_fail++; $display("[TB] FAIL wrap_addr1: got %h expected 00000000", imem_addr_o); end
    tick();
    n_checks++; if (out_pc_o !== 32'hFFFFFFFC) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected fffffffc", out_pc_o); end
    n_checks++; if (out_pc4_o !== 32'h00000000) begin n_fail++; $display("[TB] FAIL wrap_pc4: got %h expected 00000000", out_pc4_o); end
  endtask

  task automatic test_flush_priority();
    logic found;
    do_reset();
    gnt = 1'b1; ready = 1'b1; resp_en = 1'b1;
    repeat (3) tick();
    flush = 1'b1; new_pc = 32'hBFC00380; redirect = 1'b1; redirect_pc = 32'h00400100;
    tick();
    flush = 1'b0; redirect = 1'b0;
    n_checks++; if (imem_addr_o !== 32'hBFC00380) begin n_fail++; $display("[TB] FAIL flush_addr: got %h expected bfc00380", imem_addr_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty: got %b expected 0", out_valid_o); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (out_valid_o) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_timeout: got %b expected 1", found); end
    n_checks++; if (out_pc_o !== 32'hBFC00380) begin n_fail++; $display("[TB] FAIL flush_first_pc: got %h expected bfc00380", out_pc_o); end
  endtask

  task automatic test_misaligned();
    int g0;
    do_reset();
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h00400102;
    tick();
    redirect = 1'b0;
    g0 = grant_cnt;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_no_req: got %b expected 0", imem_req_o); end
    tick();
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_valid: got %b expected 1", out_valid_o); end
    n_checks++; if (out_pc_o !== 32'h00400102) begin n_fail++; $display("[TB] FAIL mis_pc: got %h expected 00400102", out_pc_o); end
    n_checks++; if (out_instr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL mis_instr: got %h expected 00000000", out_instr_o); end
    n_checks++; if (out_except_o !== 8'h80) begin n_fail++; $display("[TB] FAIL mis_except: got %h expected 80", out_except_o); end
    n_checks++; if (out_pc4_o !== 32'h00400106) begin n_fail++; $display("[TB] FAIL mis_pc4: got %h expected 00400106", out_pc4_o); end
    repeat (4) tick();
    n_checks++; if (grant_cnt !== g0) begin n_fail++; $display("[TB] FAIL mis_halt_grants: got %0d expected %0d", grant_cnt, g0); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_single_entry: got %b expected 0", out_valid_o); end
    tick();
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_still_halted: got %b expected 0", imem_req_o); end
    redirect = 1'b1; redirect_pc = 32'h00400200;
    tick();
    redirect = 1'b0;
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_resume_req: got %b expected 1", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'h00400200) begin n_fail++; $display("[TB] FAIL mis_resume_addr: got %h expected 00400200", imem_addr_o); end
  endtask

  task automatic test_midreset();
    do_reset();
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    repeat (8) tick();
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mrst_full_valid: got %b expected 1", out_valid_o); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mrst_valid_now: got %b expected 0", out_valid_o); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mrst_req_now: got %b expected 0", imem_req_o); end
    pend_q.delete();
    rvalid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mrst_req_after: got %b expected 1", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'hBFC00000) begin n_fail++; $display("[TB] FAIL mrst_addr_after: got %h expected bfc00000", imem_addr_o); end
    tick(); tick();
    n_checks++; if (out_pc_o !== 32'hBFC00000) begin n_fail++; $display("[TB] FAIL mrst_first_pc: got %h expected bfc00000", out_pc_o); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; redirect = 1'b0; gnt = 1'b0; ready = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; new_pc = 32'h0; redirect_pc = 32'h0;
    resp_en = 1'b0; grant_cnt = 0; last_grant_addr = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_flush_priority();
    test_misaligned();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch entries; power of two, >=2.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush_i  input  1  exception redirect; highest priority.
REQ-006 SHALL have port new_pc_i  input  32  exception handler address, used with flush_i.
REQ-007 SHALL have port redirect_i  input  1  branch/jump redirect from ID.
REQ-008 SHALL have port redirect_pc_i  input  32  branch/jump target, used with redirect_i.
REQ-009 SHALL have port imem_req_o  output  1  instruction memory request valid.
REQ-010 SHALL have port imem_addr_o  output  32  request address; equals fetch PC.
REQ-011 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-012 SHALL have port imem_rvalid_i  input  1  response valid; responses return in request order, >=1 cycle after grant.
REQ-013 SHALL have port imem_rdata_i  input  32  response instruction word.
REQ-014 SHALL have port out_valid_o  output  1  head entry valid.
REQ-015 SHALL have port out_pc_o  output  32  head entry PC.
REQ-016 SHALL have port out_instr_o  output  32  head entry instruction.
REQ-017 SHALL have port out_except_o  output  8  head entry exception code; 8'h80 = fetch address error, else 8'h00.
REQ-018 SHALL have port out_ready_i  input  1  consumer accepts head entry.
REQ-019 SHALL have port out_pc4_o  output  32  out_pc_o + 4, modulo 2^32.

Function
REQ-020 SHALL hold a fetch PC, a DEPTH-entry FIFO of {pc, instr, except}, an in-flight count, and a discard count.
REQ-021 SHALL assert imem_req_o only when fetch PC[1:0]==0, fetch is not halted, and FIFO occupancy + in-flight < DEPTH.
REQ-022 SHALL, on imem_req_o && imem_gnt_i, advance fetch PC by 4 (wraps at 2^32) and increment in-flight.
REQ-023 SHALL keep imem_addr_o stable while imem_req_o is high and not granted, unless flushed or redirected.
REQ-024 SHALL, on imem_rvalid_i with discard count 0, push {pc, imem_rdata_i, 8'h00} into the FIFO in request order and decrement in-flight.
REQ-025 SHALL, on imem_rvalid_i with discard count > 0, drop the data and decrement discard.
REQ-026 SHALL, when fetch PC[1:0]!=0 and space exists, push {PC, 32'h0, 8'h80} without a memory request, then halt fetch until flush_i or redirect_i.
REQ-027 SHALL pop the head on out_valid_o && out_ready_i; a push and a pop in the same cycle are both performed and occupancy is unchanged.
REQ-028 SHALL hold the head entry stable while out_valid_o && !out_ready_i.
REQ-029 SHALL, on flush_i, load new_pc_i into the fetch PC; otherwise, on redirect_i, load redirect_pc_i; flush_i wins when both are high.
REQ-030 SHALL, on flush_i or redirect_i, clear the FIFO, clear halt, move in-flight into discard, and count a request granted that same cycle as discard.
REQ-031 SHALL drop any imem_rvalid_i arriving in the flush/redirect cycle by decrementing discard or in-flight.
REQ-032 SHALL issue the first request at the new PC no earlier than the cycle after the redirect.
REQ-033 SHALL never overflow the FIFO, and SHALL keep in-flight + discard <= DEPTH.

Reset
REQ-034 SHALL, while rst_i is high, force fetch PC=RESET_PC, FIFO empty, in-flight=0, discard=0, halt=0, imem_req_o=0, and out_valid_o=0.
REQ-035 SHALL make out_pc_o, out_instr_o and out_except_o read 0 while the FIFO is empty after reset.
REQ-036 SHALL abandon pending responses on reset assertion mid-operation, and SHALL reach the REQ-034 state at the first edge after release.

Verification
REQ-037 SHALL be verified for reset release with gnt=1 and 1-cycle rvalid: requests to BFC00000, BFC00004, and so on, with out_pc4_o = out_pc_o + 4.
REQ-038 SHALL be verified for backpressure: out_ready_i=0, DEPTH=4 -> exactly 4 grants, then imem_req_o=0; one pop -> exactly one more request.
REQ-039 SHALL be verified for redirect: redirect_i with redirect_pc_i=00400100 while 2 requests are in flight -> both responses dropped, FIFO empty, next request 00400100.
REQ-040 SHALL be verified for simultaneous events: flush_i=1 with new_pc_i=BFC00380 and redirect_i=1 -> next request BFC00380.
REQ-041 SHALL be verified for a misaligned target: redirect to 00400102 -> one entry {00400102, 0, 80}, no memory request, halt until the next redirect.
REQ-042 SHALL be verified for mid-operation reset: rst_i asserted with a full FIFO -> out_valid_o=0 immediately, then a fresh fetch from BFC00000.
